// File: rtl/cordic_prerotate.sv
// -----------------------------------------------------------------------------
// cordic_prerotate
//
// Front end of the CORDIC chain. Owns the NCO (frequency register plus phase
// accumulator). Each valid I/Q sample is sign-extended with two guard bits and
// paired with its NCO phase. The pair is then rotated by 0 or +/-90 degrees so
// that the residual phase handed to cordic_stage 0 lies in [-90, +90) degrees.
//
// Pipeline
//   stage 1 : sign extension and phase truncation. Loaded only on in_valid.
//   stage 2 : quadrant pre-rotation. Registered every cycle.
//   Latency is 2 clocks and throughput is one sample per clock.
//
// Parameters
//   IN_WIDTH      input sample width, two's complement (default 14)
//   CORDIC_WIDTH  output I/Q width; must equal IN_WIDTH+2 (default 16)
//   ACC_WIDTH     phase accumulator / frequency word width (default 32)
//   PHASE_WIDTH   output phase width. ACC_WIDTH-PHASE_WIDTH must be in 1..16
//                 (default 16).
//
// Ports
//   clk        in   sample-domain clock
//   reset_n    in   asynchronous, active-low reset
//   Iin, Qin   in   input samples, IN_WIDTH each
//   in_valid   in   Iin/Qin valid this cycle; also advances the NCO
//   freq_in    in   phase increment per valid sample (full scale = 360 deg)
//   freq_load  in   one-cycle strobe that captures freq_in
//   phase_clr  in   one-cycle strobe that zeroes the accumulator
//   Iout, Qout out  pre-rotated samples, CORDIC_WIDTH each
//   PHout      out  residual phase, MSB-signed, full scale +/-180 deg
//   out_valid  out  Iout/Qout/PHout valid
//
// Build option
//   CORDIC_PREROTATE_DITHER_EN  When this macro is defined, the design adds
//     a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1). The LFSR
//     shifts once per valid sample. Its low ACC_WIDTH-PHASE_WIDTH bits are
//     added to the sample phase before truncation.
//     When the macro is undefined, the phase is truncated directly.
// -----------------------------------------------------------------------------
module cordic_prerotate #(
    parameter int IN_WIDTH     = 14,
    parameter int CORDIC_WIDTH = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int PHASE_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [IN_WIDTH-1:0]     Iin,
    input  logic [IN_WIDTH-1:0]     Qin,
    input  logic                    in_valid,
    input  logic [ACC_WIDTH-1:0]    freq_in,
    input  logic                    freq_load,
    input  logic                    phase_clr,
    output logic [CORDIC_WIDTH-1:0] Iout,
    output logic [CORDIC_WIDTH-1:0] Qout,
    output logic [PHASE_WIDTH-1:0]  PHout,
    output logic                    out_valid
);

    // Accumulator bits that fall below the output phase LSB.
    localparam int FRAC_W  = ACC_WIDTH - PHASE_WIDTH;
    localparam int GUARD_W = CORDIC_WIDTH - IN_WIDTH;

    // -------------------------------------------------------------------------
    // NCO: frequency register and phase accumulator
    // -------------------------------------------------------------------------
    logic [ACC_WIDTH-1:0] freq_q, freq_d;
    logic [ACC_WIDTH-1:0] acc_q,  acc_d;
    logic [ACC_WIDTH-1:0] sample_phase;

    // A freq_load takes effect at the clock edge. A sample in the same cycle
    // therefore still advances the accumulator with the old increment.
    assign freq_d = freq_load ? freq_in : freq_q;

    // phase_clr makes the same-cycle sample see phase 0. The accumulator
    // restarts one increment ahead of that sample.
    assign sample_phase = phase_clr ? '0 : acc_q;

    always_comb begin
        acc_d = acc_q;
        if (in_valid) begin
            acc_d = sample_phase + freq_q;    // silent modulo-2^ACC_WIDTH wrap
        end else if (phase_clr) begin
            acc_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Optional phase dither ahead of truncation
    // -------------------------------------------------------------------------
    logic [ACC_WIDTH-1:0] dithered_phase;

`ifdef CORDIC_PREROTATE_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // The LFSR is deliberately left alone by phase_clr so the dither sequence
    // stays decorrelated from phase restarts.
    assign lfsr_d  = in_valid ? {lfsr_q[14:0], lfsr_fb} : lfsr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign dithered_phase = sample_phase
                          + {{PHASE_WIDTH{1'b0}}, lfsr_q[FRAC_W-1:0]};
`else
    assign dithered_phase = sample_phase;
`endif

    logic [PHASE_WIDTH-1:0] ph;
    assign ph = dithered_phase[ACC_WIDTH-1 -: PHASE_WIDTH];

    // The fractional phase bits are intentionally discarded by truncation.
    logic unused_frac_bits;
    assign unused_frac_bits = ^dithered_phase[FRAC_W-1:0];

    // -------------------------------------------------------------------------
    // Stage 1: guard-bit sign extension and phase capture
    // -------------------------------------------------------------------------
    logic [CORDIC_WIDTH-1:0] i1_q, i1_d;
    logic [CORDIC_WIDTH-1:0] q1_q, q1_d;
    logic [PHASE_WIDTH-1:0]  ph1_q, ph1_d;
    logic                    v1_q;

    // The data registers only load on valid samples. Idle cycles keep the
    // last sample.
    always_comb begin
        i1_d  = i1_q;
        q1_d  = q1_q;
        ph1_d = ph1_q;
        if (in_valid) begin
            i1_d  = {{GUARD_W{Iin[IN_WIDTH-1]}}, Iin};
            q1_d  = {{GUARD_W{Qin[IN_WIDTH-1]}}, Qin};
            ph1_d = ph;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: quadrant pre-rotation
    // -------------------------------------------------------------------------
    // The two phase MSBs select the quadrant. Quadrants 00 and 11 already lie
    // in [-90, +90) and pass through unchanged.
    // Quadrant 01 is rotated by +90 deg: (I,Q) -> (-Q, I), and 90 deg is
    //   removed from the phase.
    // Quadrant 10 is rotated by -90 deg: (I,Q) -> (Q, -I), and 90 deg is
    //   added to the phase.
    // Rewriting the top two phase bits performs that +/-90 deg phase shift.
    // Thanks to the guard bits, negating a sign-extended sample cannot
    // overflow.
    logic [CORDIC_WIDTH-1:0] iout_q, iout_d;
    logic [CORDIC_WIDTH-1:0] qout_q, qout_d;
    logic [PHASE_WIDTH-1:0]  phout_q, phout_d;
    logic                    out_valid_q;

    always_comb begin
        iout_d  = i1_q;
        qout_d  = q1_q;
        phout_d = ph1_q;
        case (ph1_q[PHASE_WIDTH-1 -: 2])
            2'b01: begin
                iout_d  = -q1_q;
                qout_d  = i1_q;
                phout_d = {2'b00, ph1_q[PHASE_WIDTH-3:0]};
            end
            2'b10: begin
                iout_d  = q1_q;
                qout_d  = -i1_q;
                phout_d = {2'b11, ph1_q[PHASE_WIDTH-3:0]};
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            freq_q      <= '0;
            acc_q       <= '0;
            i1_q        <= '0;
            q1_q        <= '0;
            ph1_q       <= '0;
            v1_q        <= 1'b0;
            iout_q      <= '0;
            qout_q      <= '0;
            phout_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            freq_q      <= freq_d;
            acc_q       <= acc_d;
            i1_q        <= i1_d;
            q1_q        <= q1_d;
            ph1_q       <= ph1_d;
            v1_q        <= in_valid;
            iout_q      <= iout_d;
            qout_q      <= qout_d;
            phout_q     <= phout_d;
            out_valid_q <= v1_q;
        end
    end

    assign Iout      = iout_q;
    assign Qout      = qout_q;
    assign PHout     = phout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cordic_prerotate.sv
// -----------------------------------------------------------------------------
// Testbench for cordic_prerotate.
//
// A behavioural model follows the NCO and the rotation rules using integer
// arithmetic. On every clock it checks out_valid, and on every valid output it
// checks Iout, Qout and PHout. Directed scenarios add literal expectations,
// worked out by hand, on the captured output samples.
// -----------------------------------------------------------------------------
module tb_cordic_prerotate;

    localparam int IW = 14;
    localparam int CW = 16;
    localparam int AW = 32;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [IW-1:0] Iin, Qin;
    logic          in_valid;
    logic [AW-1:0] freq_in;
    logic          freq_load, phase_clr;
    logic [CW-1:0] Iout, Qout;
    logic [PW-1:0] PHout;
    logic          out_valid;

    cordic_prerotate #(
        .IN_WIDTH(IW), .CORDIC_WIDTH(CW), .ACC_WIDTH(AW), .PHASE_WIDTH(PW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .Iin(Iin), .Qin(Qin),
        .in_valid(in_valid), .freq_in(freq_in), .freq_load(freq_load),
        .phase_clr(phase_clr), .Iout(Iout), .Qout(Qout), .PHout(PHout),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Valid output samples, in the order they leave the DUT.
    int obs_i[$];
    int obs_q[$];
    int obs_ph[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic lit_sample(input string name, input int idx,
                              input int ei, input int eq, input int eph);
        checks++;
        if (idx >= obs_ph.size()) begin
            failures++;
            $display("FAIL %s_missing actual=%0d samples required>%0d", name, obs_ph.size(), idx);
        end else begin
            chk({name, "_I"},  obs_i[idx],  ei);
            chk({name, "_Q"},  obs_q[idx],  eq);
            chk({name, "_PH"}, obs_ph[idx], eph);
            $display("sample %s: I=%0d Q=%0d PH=0x%04h", name, obs_i[idx], obs_q[idx], obs_ph[idx]);
        end
    endtask

    // ---------------------------------------------------------------- model
    initial begin : compare
        logic [AW-1:0] m_freq, m_acc, sph, dph;
        logic [15:0]   m_lfsr;
        bit            m_pv;
        int            m_ei, m_eq, m_eph;
        int            si, sq, p, ri, rq;
        m_freq = '0; m_acc = '0; m_lfsr = 16'hACE1; m_pv = 0;
        m_ei = 0; m_eq = 0; m_eph = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset_n) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_Iout", Iout, 0);
                chk("rst_Qout", Qout, 0);
                chk("rst_PHout", PHout, 0);
                m_freq = '0; m_acc = '0; m_lfsr = 16'hACE1; m_pv = 0;
            end else begin
                chk("out_valid", out_valid, m_pv);
                if (m_pv) begin
                    chk("Iout", $signed(Iout), m_ei);
                    chk("Qout", $signed(Qout), m_eq);
                    chk("PHout", PHout, m_eph);
                end
                if (out_valid) begin
                    obs_i.push_back($signed(Iout));
                    obs_q.push_back($signed(Qout));
                    obs_ph.push_back(PHout);
                end
                // The inputs sampled at this edge are still on the bus.
                if (in_valid) begin
                    sph = phase_clr ? '0 : m_acc;
`ifdef CORDIC_PREROTATE_DITHER_EN
                    dph = sph + {16'h0000, m_lfsr};
                    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`else
                    dph = sph;
`endif
                    p  = dph[AW-1:AW-PW];
                    si = $signed(Iin);
                    sq = $signed(Qin);
                    ri = si; rq = sq;
                    if (p >= 16384 && p < 32768) begin        // +90..+180: multiply by +j
                        ri = -sq; rq = si; p = p - 16384;
                    end else if (p >= 32768 && p < 49152) begin // -180..-90: multiply by -j
                        ri = sq; rq = -si; p = p + 16384;
                    end
                    m_ei = ri; m_eq = rq; m_eph = p;
                    m_acc = sph + m_freq;
                end else if (phase_clr) begin
                    m_acc = '0;
                end
                m_pv = in_valid;
                if (freq_load) m_freq = freq_in;
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic drive(input bit v, input int i, input int q,
                         input bit fl, input logic [AW-1:0] f, input bit pc);
        @(negedge clk);
        in_valid  = v;
        Iin       = i[IW-1:0];
        Qin       = q[IW-1:0];
        freq_load = fl;
        freq_in   = f;
        phase_clr = pc;
    endtask

    task automatic samp(input int i, input int q);
        drive(1, i, q, 0, '0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, '0, 0);
    endtask

    task automatic load_freq(input logic [AW-1:0] f);
        drive(0, 0, 0, 1, f, 0);
    endtask

    task automatic clr();
        drive(0, 0, 0, 0, '0, 1);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin : stim
        int base;
        int vi, vq;
        reset_n = 1'b0; in_valid = 0; Iin = '0; Qin = '0;
        freq_in = '0; freq_load = 0; phase_clr = 0;

        // Reset hold: stimulus is ignored while reset_n is low.
        repeat (3) drive(1, 1234, -321, 1, 32'h1111_1111, 1);
        chk("hold_out_valid", out_valid, 0);
        chk("hold_Iout", Iout, 0);
        chk("hold_PHout", PHout, 0);
        idle(1);
        reset_n = 1'b1;

        // First sample after reset: freq_reg = 0, two-clock latency.
        base = obs_ph.size();
        samp(100, -50);
        idle(1);
        chk("lat_after_1clk", out_valid, 0);
        idle(1);
        chk("lat_after_2clk", out_valid, 1);
        idle(2);
        lit_sample("first", base, 100, -50, 0);

        // Quadrant walk at 90 degrees per sample.
        load_freq(32'h4000_0000);
        clr();
        base = obs_ph.size();
        repeat (4) samp(1000, 0);
        idle(3);
        lit_sample("quad0", base + 0, 1000, 0, 16'h0000);
        lit_sample("quad1", base + 1, 0, 1000, 16'h0000);
        lit_sample("quad2", base + 2, 0, -1000, 16'hC000);
        lit_sample("quad3", base + 3, 1000, 0, 16'hC000);

        // Full-scale negative input in quadrant 01.
        clr();
        base = obs_ph.size();
        samp(0, 0);
        samp(-8192, -8192);
        idle(3);
        lit_sample("fullscale", base + 1, 8192, -8192, 16'h0000);

        // freq_load together with in_valid, then phase_clr with in_valid.
        load_freq(32'h0200_0000);
        clr();
        base = obs_ph.size();
        drive(1, 1, 2, 1, 32'h0100_0000, 0);
        samp(1, 2);
        samp(1, 2);
        drive(1, 1, 2, 0, '0, 1);
        samp(1, 2);
        idle(3);
        lit_sample("strobe0", base + 0, 1, 2, 16'h0000);
        lit_sample("strobe1", base + 1, 1, 2, 16'h0200);
        lit_sample("strobe2", base + 2, 1, 2, 16'h0300);
        lit_sample("strobe3", base + 3, 1, 2, 16'h0000);
        lit_sample("strobe4", base + 4, 1, 2, 16'h0100);

        // Wrap-around with a negative increment, and idle gaps holding acc.
        load_freq(32'hFFFF_FFFF);
        clr();
        base = obs_ph.size();
        repeat (3) samp(5, 7);
        idle(3);
`ifndef CORDIC_PREROTATE_DITHER_EN
        lit_sample("wrap0", base + 0, 5, 7, 16'h0000);
        lit_sample("wrap1", base + 1, 5, 7, 16'hFFFF);
        lit_sample("wrap2", base + 2, 5, 7, 16'hFFFF);
`endif
        load_freq(32'hFFFF_0000);
        clr();
        base = obs_ph.size();
        samp(5, 7);
        samp(5, 7);
        idle(4);
        samp(5, 7);
        idle(2);
        samp(5, 7);
        idle(3);
`ifndef CORDIC_PREROTATE_DITHER_EN
        lit_sample("gap0", base + 0, 5, 7, 16'h0000);
        lit_sample("gap1", base + 1, 5, 7, 16'hFFFF);
        lit_sample("gap2", base + 2, 5, 7, 16'hFFFE);
        lit_sample("gap3", base + 3, 5, 7, 16'hFFFD);
`endif

        // Plain truncation of a sub-LSB increment.
        load_freq(32'h0000_8000);
        clr();
        base = obs_ph.size();
        repeat (4) samp(3, -3);
        idle(3);
`ifndef CORDIC_PREROTATE_DITHER_EN
        lit_sample("trunc0", base + 0, 3, -3, 16'h0000);
        lit_sample("trunc1", base + 1, 3, -3, 16'h0000);
        lit_sample("trunc2", base + 2, 3, -3, 16'h0001);
        lit_sample("trunc3", base + 3, 3, -3, 16'h0001);
`endif

        // Reset mid-stream: the sample still in stage 1 is dropped.
        load_freq(32'h1000_0000);
        clr();
        base = obs_ph.size();
        samp(11, 22);
        samp(33, 44);
        drive(0, 0, 0, 0, '0, 0);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(3);
        chk("midrst_count", obs_ph.size(), base + 1);
        lit_sample("midrst_kept", base, 11, 22, 16'h0000);
        samp(55, 66);
        idle(3);
        lit_sample("midrst_new", base + 1, 55, 66, 16'h0000);

        // Mixed stream with gaps and strobes, checked by the model.
        load_freq(32'h1234_5678);
        clr();
        for (int k = 0; k < 80; k++) begin
            vi = int'($urandom_range(0, 16383)) - 8192;
            vq = int'($urandom_range(0, 16383)) - 8192;
            drive((k % 4) != 3, vi, vq, (k % 17) == 5, $urandom, (k % 13) == 7);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
